// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller:
//   opcode constants, ALU command encodings, the FSM state enum and the
//   pc_src / reg_dst / wb_sel select encodings.
// Optional build macro: CTRL_ILLEGAL_TRAP_EN (adds the StHalt state).
package mips_ctrl_pkg;

    localparam int unsigned OpW = 6;

    localparam logic [OpW-1:0] OpNop  = 6'b000000;
    localparam logic [OpW-1:0] OpAdd  = 6'b000001;
    localparam logic [OpW-1:0] OpSub  = 6'b000011;
    localparam logic [OpW-1:0] OpAnd  = 6'b000101;
    localparam logic [OpW-1:0] OpOr   = 6'b000110;
    localparam logic [OpW-1:0] OpNor  = 6'b000111;
    localparam logic [OpW-1:0] OpXor  = 6'b001000;
    localparam logic [OpW-1:0] OpSla  = 6'b001001;
    localparam logic [OpW-1:0] OpSll  = 6'b001010;
    localparam logic [OpW-1:0] OpSra  = 6'b001011;
    localparam logic [OpW-1:0] OpSrl  = 6'b001100;
    localparam logic [OpW-1:0] OpAddi = 6'b100000;
    localparam logic [OpW-1:0] OpSubi = 6'b100001;
    localparam logic [OpW-1:0] OpLd   = 6'b100100;
    localparam logic [OpW-1:0] OpSt   = 6'b100101;
    localparam logic [OpW-1:0] OpBez  = 6'b101000;
    localparam logic [OpW-1:0] OpBne  = 6'b101001;
    localparam logic [OpW-1:0] OpJmp  = 6'b101010;

    typedef enum logic [3:0] {
        AluAdd = 4'd0,
        AluSub = 4'd1,
        AluAnd = 4'd2,
        AluOr  = 4'd3,
        AluNor = 4'd4,
        AluXor = 4'd5,
        AluSla = 4'd6,
        AluSll = 4'd7,
        AluSra = 4'd8,
        AluSrl = 4'd9
    } alu_cmd_e;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExecR,
        StExecI,
        StWbAlu,
        StMemAddr,
        StMemRd,
        StWbMem,
        StMemWr,
        StBranch,
        StJump
`ifdef CTRL_ILLEGAL_TRAP_EN
        , StHalt
`endif
    } state_e;

    localparam logic PcSrcSeq    = 1'b0;
    localparam logic PcSrcTarget = 1'b1;
    localparam logic RegDstRt    = 1'b0;
    localparam logic RegDstRd    = 1'b1;
    localparam logic WbSelAlu    = 1'b0;
    localparam logic WbSelMdr    = 1'b1;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bus for the multicycle MIPS core.
//   master: controller (consumes opcode/comparators/mem handshake/freeze,
//           drives every datapath enable and mux select)
//   slave : datapath/memory side
interface mips_multicycle_ctrl_if #(
    parameter int unsigned OPCODE_W = 6
);
    logic [OPCODE_W-1:0] opcode;
    logic                a_is_zero;
    logic                a_eq_b;
    logic                mem_ready;
    logic                freeze;

    logic                ir_write;
    logic                pc_write;
    logic                pc_src;
    logic                ab_write;
    logic                alu_src_b;
    logic [3:0]          alu_cmd;
    logic                alu_out_write;
    logic                mem_read;
    logic                mem_write;
    logic                mdr_write;
    logic                reg_write;
    logic                reg_dst;
    logic                wb_sel;

    modport master (
        input  opcode, a_is_zero, a_eq_b, mem_ready, freeze,
        output ir_write, pc_write, pc_src, ab_write, alu_src_b, alu_cmd, alu_out_write,
               mem_read, mem_write, mdr_write, reg_write, reg_dst, wb_sel
    );

    modport slave (
        output opcode, a_is_zero, a_eq_b, mem_ready, freeze,
        input  ir_write, pc_write, pc_src, ab_write, alu_src_b, alu_cmd, alu_out_write,
               mem_read, mem_write, mdr_write, reg_write, reg_dst, wb_sel
    );
endinterface

// File: rtl/mips_alu_dec.sv
// Combinational opcode -> ALU command lookup.
//   opcode  in  instruction opcode
//   alu_cmd out ALU operation; immediates and LD/ST map to ADD/SUB, all else ADD.
module mips_alu_dec
    import mips_ctrl_pkg::*;
(
    input  logic [OpW-1:0] opcode,
    output logic [3:0]     alu_cmd
);
    always_comb begin
        alu_cmd = AluAdd;
        case (opcode)
            OpAdd, OpAddi, OpLd, OpSt: alu_cmd = AluAdd;
            OpSub, OpSubi:             alu_cmd = AluSub;
            OpAnd:                     alu_cmd = AluAnd;
            OpOr:                      alu_cmd = AluOr;
            OpNor:                     alu_cmd = AluNor;
            OpXor:                     alu_cmd = AluXor;
            OpSla:                     alu_cmd = AluSla;
            OpSll:                     alu_cmd = AluSll;
            OpSra:                     alu_cmd = AluSra;
            OpSrl:                     alu_cmd = AluSrl;
            default:                   alu_cmd = AluAdd;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core.
//   clk, rst     clock, asynchronous active-high reset
//   bus          controller side of mips_multicycle_ctrl_if (status in, enables out)
//   illegal_op   one-cycle pulse when DECODE sees an undefined opcode
//   halted       sticky trap indication (0 unless CTRL_ILLEGAL_TRAP_EN)
//   instr_count  retired instructions, wraps modulo 2^CNT_W
// Optional build macro: CTRL_ILLEGAL_TRAP_EN -- illegal opcodes trap to a HALT state.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mips_multicycle_ctrl_if.master bus,
    output logic                 illegal_op,
    output logic                 halted,
    output logic [CNT_W-1:0]     instr_count
);
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q;
    logic [OPCODE_W-1:0] op;
    logic [3:0]          dec_cmd;

    assign op = bus.opcode;

    mips_alu_dec u_alu_dec (
        .opcode  (op),
        .alu_cmd (dec_cmd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            // Retirement is any return to FETCH from elsewhere (NOP/illegal included).
            if (state_q != StFetch && state_d == StFetch) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign instr_count = count_q;

    always_comb begin
        state_d           = state_q;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_src        = PcSrcSeq;
        bus.ab_write      = 1'b0;
        bus.alu_src_b     = 1'b0;
        bus.alu_cmd       = AluAdd;
        bus.alu_out_write = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mdr_write     = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = RegDstRt;
        bus.wb_sel        = WbSelAlu;
        illegal_op        = 1'b0;
        // Outputs are gated by rst so every enable is low while reset is held.
        if (!rst) begin
            unique case (state_q)
                StFetch: begin
                    if (!bus.freeze) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        state_d      = StDecode;
                    end
                end
                StDecode: begin
                    bus.ab_write = 1'b1;
                    case (op)
                        OpNop:                           state_d = StFetch;
                        OpAdd, OpSub, OpAnd, OpOr, OpNor,
                        OpXor, OpSla, OpSll, OpSra, OpSrl: state_d = StExecR;
                        OpAddi, OpSubi:                  state_d = StExecI;
                        OpLd, OpSt:                      state_d = StMemAddr;
                        OpBez, OpBne:                    state_d = StBranch;
                        OpJmp:                           state_d = StJump;
                        default: begin
                            illegal_op = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
                            state_d    = StHalt;
`else
                            state_d    = StFetch;
`endif
                        end
                    endcase
                end
                StExecR, StExecI: begin
                    bus.alu_src_b     = (state_q == StExecI);
                    bus.alu_cmd       = dec_cmd;
                    bus.alu_out_write = 1'b1;
                    state_d           = StWbAlu;
                end
                StWbAlu: begin
                    bus.reg_write = 1'b1;
                    // R-type writes rd, immediates write rt.
                    bus.reg_dst   = (op == OpAddi || op == OpSubi) ? RegDstRt : RegDstRd;
                    state_d       = StFetch;
                end
                StMemAddr: begin
                    bus.alu_src_b     = 1'b1;
                    bus.alu_cmd       = AluAdd;
                    bus.alu_out_write = 1'b1;
                    state_d           = (op == OpSt) ? StMemWr : StMemRd;
                end
                StMemRd: begin
                    bus.mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        bus.mdr_write = 1'b1;
                        state_d       = StWbMem;
                    end
                end
                StWbMem: begin
                    bus.reg_write = 1'b1;
                    bus.wb_sel    = WbSelMdr;
                    state_d       = StFetch;
                end
                StMemWr: begin
                    bus.mem_write = 1'b1;
                    if (bus.mem_ready) begin
                        state_d = StFetch;
                    end
                end
                StBranch: begin
                    bus.pc_src   = PcSrcTarget;
                    bus.pc_write = (op == OpBez) ? bus.a_is_zero : ~bus.a_eq_b;
                    state_d      = StFetch;
                end
                StJump: begin
                    bus.pc_src   = PcSrcTarget;
                    bus.pc_write = 1'b1;
                    state_d      = StFetch;
                end
`ifdef CTRL_ILLEGAL_TRAP_EN
                StHalt: state_d = StHalt;
`endif
                default: state_d = StFetch;
            endcase
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign halted = (state_q == StHalt);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl. A per-instruction reference
// model expands each opcode into its expected cycle-by-cycle output vectors,
// with random noise on inputs the controller must ignore.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        illegal_op;
    logic        halted;
    logic [31:0] instr_count;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.OPCODE_W(6)) bus ();

    mips_multicycle_ctrl #(
        .OPCODE_W (6),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .illegal_op  (illegal_op),
        .halted      (halted),
        .instr_count (instr_count)
    );

    // Expected-vector bit masks.
    localparam logic [17:0] IR  = 18'd1 << 17;
    localparam logic [17:0] PCW = 18'd1 << 16;
    localparam logic [17:0] PCS = 18'd1 << 15;
    localparam logic [17:0] AB  = 18'd1 << 14;
    localparam logic [17:0] ASB = 18'd1 << 13;
    localparam logic [17:0] AOW = 18'd1 << 8;
    localparam logic [17:0] MRD = 18'd1 << 7;
    localparam logic [17:0] MWR = 18'd1 << 6;
    localparam logic [17:0] MDR = 18'd1 << 5;
    localparam logic [17:0] RW  = 18'd1 << 4;
    localparam logic [17:0] RD  = 18'd1 << 3;
    localparam logic [17:0] WB  = 18'd1 << 2;
    localparam logic [17:0] ILL = 18'd1 << 1;
    localparam logic [17:0] HLT = 18'd1;

    typedef struct packed {
        logic        fz;
        logic        mr;
        logic        az;
        logic        ae;
        logic [17:0] exp;
    } cyc_t;

    cyc_t        q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_cnt;
    logic [5:0]  legal_ops[18] = '{6'b000000, 6'b000001, 6'b000011, 6'b000101, 6'b000110,
                                   6'b000111, 6'b001000, 6'b001001, 6'b001010, 6'b001011,
                                   6'b001100, 6'b100000, 6'b100001, 6'b100100, 6'b100101,
                                   6'b101000, 6'b101001, 6'b101010};

    function automatic logic [17:0] observed();
        return {bus.ir_write, bus.pc_write, bus.pc_src, bus.ab_write, bus.alu_src_b,
                bus.alu_cmd, bus.alu_out_write, bus.mem_read, bus.mem_write, bus.mdr_write,
                bus.reg_write, bus.reg_dst, bus.wb_sel, illegal_op, halted};
    endfunction

    // 0 NOP, 1 R-type, 2 immediate, 3 LD, 4 ST, 5 BEZ, 6 BNE, 7 JMP, 8 illegal
    function automatic int op_class(input logic [5:0] op);
        case (op)
            6'b000000: return 0;
            6'b000001, 6'b000011, 6'b000101, 6'b000110, 6'b000111,
            6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100: return 1;
            6'b100000, 6'b100001: return 2;
            6'b100100: return 3;
            6'b100101: return 4;
            6'b101000: return 5;
            6'b101001: return 6;
            6'b101010: return 7;
            default:   return 8;
        endcase
    endfunction

    function automatic logic [17:0] cmd_bits(input logic [5:0] op);
        logic [3:0] c;
        case (op)
            6'b000011, 6'b100001: c = 4'd1;
            6'b000101: c = 4'd2;
            6'b000110: c = 4'd3;
            6'b000111: c = 4'd4;
            6'b001000: c = 4'd5;
            6'b001001: c = 4'd6;
            6'b001010: c = 4'd7;
            6'b001011: c = 4'd8;
            6'b001100: c = 4'd9;
            default:   c = 4'd0;
        endcase
        return {5'd0, c, 9'd0};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic fz, input logic mr, input logic az,
                                 input logic ae, input logic [17:0] e);
        cyc_t c;
        c.fz = fz; c.mr = mr; c.az = az; c.ae = ae; c.exp = e;
        q.push_back(c);
    endfunction

    // Instruction-level model: fetch (with optional freeze), decode, then the
    // class-specific tail. mem_ready/freeze carry noise wherever they are ignored.
    function automatic void build(input logic [5:0] op, input int nfz, input int wt,
                                  input logic br_az, input logic br_ae);
        int c = op_class(op);
        for (int i = 0; i < nfz; i++) push(1'b1, rb(), rb(), rb(), '0);
        push(1'b0, rb(), rb(), rb(), IR | PCW);
        push(rb(), rb(), rb(), rb(), AB | ((c == 8) ? ILL : 18'd0));
        case (c)
            1: begin
                push(rb(), rb(), rb(), rb(), cmd_bits(op) | AOW);
                push(rb(), rb(), rb(), rb(), RW | RD);
            end
            2: begin
                push(rb(), rb(), rb(), rb(), ASB | cmd_bits(op) | AOW);
                push(rb(), rb(), rb(), rb(), RW);
            end
            3: begin
                push(rb(), rb(), rb(), rb(), ASB | AOW);
                for (int i = 0; i < wt; i++) push(rb(), 1'b0, rb(), rb(), MRD);
                push(rb(), 1'b1, rb(), rb(), MRD | MDR);
                push(rb(), rb(), rb(), rb(), RW | WB);
            end
            4: begin
                push(rb(), rb(), rb(), rb(), ASB | AOW);
                for (int i = 0; i < wt; i++) push(rb(), 1'b0, rb(), rb(), MWR);
                push(rb(), 1'b1, rb(), rb(), MWR);
            end
            5: push(rb(), rb(), br_az, br_ae, PCS | (br_az ? PCW : 18'd0));
            6: push(rb(), rb(), br_az, br_ae, PCS | (!br_ae ? PCW : 18'd0));
            7: push(rb(), rb(), rb(), rb(), PCS | PCW);
            default: ;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Play up to n queued cycles: inputs at posedge+1, outputs checked at negedge.
    task automatic play(input int n);
        cyc_t c;
        int   k = 0;
        while (q.size() > 0 && k < n) begin
            c = q.pop_front();
            bus.freeze    = c.fz;
            bus.mem_ready = c.mr;
            bus.a_is_zero = c.az;
            bus.a_eq_b    = c.ae;
            @(negedge clk);
            check($sformatf("op=%b cyc=%0d", bus.opcode, k), 32'(observed()), 32'(c.exp));
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic run(input logic [5:0] op, input int nfz, input int wt,
                       input logic az, input logic ae);
        bus.opcode = op;
        build(op, nfz, wt, az, ae);
        play(1000);
        model_cnt = model_cnt + 1;
        check($sformatf("count after op=%b", op), instr_count, model_cnt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("reset outputs", 32'(observed()), 32'd0);
        check("reset count", instr_count, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_cnt = '0;
    endtask

    initial begin
        logic [31:0] c0;
        logic [5:0]  op;
        bus.opcode    = '0;
        bus.freeze    = 1'b0;
        bus.mem_ready = 1'b0;
        bus.a_is_zero = 1'b0;
        bus.a_eq_b    = 1'b0;
        model_cnt     = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Directed: ADD, LD with 3 wait cycles, branches, NOP, ST with no wait.
        run(6'b000001, 0, 0, 1'b0, 1'b0);
        run(6'b100100, 0, 3, 1'b0, 1'b0);
        run(6'b101000, 0, 0, 1'b0, 1'b1);
        run(6'b101000, 0, 0, 1'b1, 1'b1);
        run(6'b101001, 0, 0, 1'b0, 1'b0);
        run(6'b101001, 0, 0, 1'b1, 1'b1);
        run(6'b000000, 0, 0, 1'b0, 1'b0);
        run(6'b100101, 0, 0, 1'b0, 1'b0);

        // JMP x10 with one freeze cycle.
        c0 = instr_count;
        for (int i = 0; i < 10; i++) run(6'b101010, (i == 3) ? 1 : 0, 0, 1'b0, 1'b0);
        check("jmp10 delta", instr_count - c0, 32'd10);

        // Reset in the middle of an LD wait.
        bus.opcode = 6'b100100;
        build(6'b100100, 0, 6, 1'b0, 1'b0);
        play(5);
        q.delete();
        bus.mem_ready = 1'b0;
        check("mem_read before reset", 32'(bus.mem_read), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mem_read dropped on reset", 32'(bus.mem_read), 32'd0);
        check("count cleared on reset", instr_count, 32'd0);
        @(posedge clk);
        #1;
        do_reset();
        run(6'b001100, 0, 0, 1'b0, 1'b0);

        // Randomised instruction stream.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(0, 63));
            else op = legal_ops[$urandom_range(0, 17)];
`ifdef CTRL_ILLEGAL_TRAP_EN
            if (op_class(op) == 8) op = 6'b000000;
`endif
            run(op, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                int'($urandom_range(0, 3)), rb(), rb());
        end

`ifdef CTRL_ILLEGAL_TRAP_EN
        bus.opcode = 6'b111111;
        push(1'b0, rb(), rb(), rb(), IR | PCW);
        push(rb(), rb(), rb(), rb(), AB | ILL);
        for (int i = 0; i < 20; i++) push(rb(), rb(), rb(), rb(), HLT);
        play(1000);
        check("count frozen in halt", instr_count, model_cnt);
        do_reset();
        check("halted cleared", 32'(halted), 32'd0);
        run(6'b000001, 0, 0, 1'b0, 1'b0);
`else
        run(6'b111111, 0, 0, 1'b0, 1'b0);
        check("halted tied low", 32'(halted), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
